// File: rtl/bist_seq_ctrl.sv
// bist_seq_ctrl: LFSR-driven BIST sequencer with MISR response compaction and golden compare
module bist_seq_ctrl #(
    parameter int          N_IN     = 7,
    parameter int          N_PAT    = 256,
    parameter int          LAT      = 3,
    parameter logic [15:0] SEED_DEF = 16'hACE1
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            start,
    input  logic            abort,
    input  logic [15:0]     seed,
    input  logic [15:0]     golden_sig,
    output logic [N_IN-1:0] dut_in,
    output logic            dut_rst,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     signature
);
    typedef enum logic [2:0] {IDLE, DUT_RST, APPLY, DRAIN, CMP, DONE} state_t;
    localparam int CW = $clog2(N_PAT + 16);
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [15:0]   lfsr, lfsr_nxt, misr_nxt, gold;
    logic          accept, kill, last_pat, applied, valid;
    assign accept   = (state == IDLE || state == DONE) && start;
    assign kill     = busy && abort;
    assign last_pat = cnt == CW'(N_PAT - 1);
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign misr_nxt = {signature[14:0], signature[15] ^ signature[13] ^ signature[12] ^ signature[10]} ^ {15'b0, dut_out};
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state || !busy) ? '0 : cnt + 1'b1;
        end
    end
    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = DUT_RST;
        else if (kill)
            state_nxt = IDLE;
        else if (state == DUT_RST && cnt == CW'(1))
            state_nxt = APPLY;
        else if (state == APPLY && last_pat)
            state_nxt = (LAT == 0) ? CMP : DRAIN;
        else if (state == DRAIN && cnt == CW'(LAT - 1))
            state_nxt = CMP;
        else if (state == CMP)
            state_nxt = DONE;
    end
    always_comb begin
        busy    = state inside {DUT_RST, APPLY, DRAIN, CMP};
        done    = state == DONE;
        dut_rst = sys_rst && state != DUT_RST;
        applied = state == APPLY;
    end
    // dut_in is loaded one step ahead so pattern k is on the bus during APPLY cycle k
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            lfsr      <= '0;
            gold      <= '0;
            signature <= '0;
            pass      <= 1'b0;
            dut_in    <= '0;
        end else if (accept) begin
            gold      <= golden_sig;
            lfsr      <= (seed == 16'h0) ? SEED_DEF : seed;
            signature <= '0;
            pass      <= 1'b0;
            dut_in    <= '0;
        end else if (kill) begin
            pass   <= 1'b0;
            dut_in <= '0;
        end else begin
            if (state == DUT_RST && cnt == CW'(1))
                dut_in <= lfsr[N_IN-1:0];
            if (applied)
                lfsr <= lfsr_nxt;
            if (applied && !last_pat)
                dut_in <= lfsr_nxt[N_IN-1:0];
            if (valid)
                signature <= misr_nxt;
            if (state == CMP)
                pass <= signature == gold;
        end
    end
    generate
        if (LAT == 0) begin : g_nopipe
            assign valid = applied;
        end else begin : g_pipe
            logic [LAT-1:0] vpipe;
            always_ff @(posedge sys_clk or negedge sys_rst) begin
                if (!sys_rst)
                    vpipe <= '0;
                else if (accept || kill)
                    vpipe <= '0;
                else
                    vpipe <= LAT'({vpipe, applied});
            end
            assign valid = vpipe[LAT-1];
        end
    endgenerate
endmodule

// File: tb/tb_bist_seq_ctrl.sv
// tb_bist_seq_ctrl: directed bench with a timeline model of the sequencer checked every cycle
module tb_bist_seq_ctrl;
    localparam int N = 256;
    localparam int L = 3;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n, start, abort, mode, chk_on;
    logic [15:0] seed, golden;
    logic [6:0]  din0, din1, din2, h1, h2, h3, g1, g2, g3;
    logic        drst0, drst1, drst2, dout0, dout1, dout2;
    logic        busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [15:0] sig0, sig1, sig2;
    int          n_tot = 0, n_ok = 0, ncyc = 0, e0 = 0;

    bist_seq_ctrl u0 (.sys_clk(clk), .sys_rst(rst_n), .start(start), .abort(abort), .seed(seed),
        .golden_sig(golden), .dut_in(din0), .dut_rst(drst0), .dut_out(dout0), .busy(busy0),
        .done(done0), .pass(pass0), .signature(sig0));
    bist_seq_ctrl #(.N_PAT(4), .LAT(3)) u1 (.sys_clk(clk), .sys_rst(rst_n), .start(start), .abort(abort),
        .seed(seed), .golden_sig(golden), .dut_in(din1), .dut_rst(drst1), .dut_out(dout1), .busy(busy1),
        .done(done1), .pass(pass1), .signature(sig1));
    bist_seq_ctrl #(.N_PAT(4), .LAT(0)) u2 (.sys_clk(clk), .sys_rst(rst_n), .start(start), .abort(abort),
        .seed(seed), .golden_sig(golden), .dut_in(din2), .dut_rst(drst2), .dut_out(dout2), .busy(busy2),
        .done(done2), .pass(pass2), .signature(sig2));

    // stand-in circuits under test: parity / echo of the pattern, 3 cycles late (u2 undelayed)
    always @(posedge clk) begin
        h1 <= din0; h2 <= h1; h3 <= h2;
        g1 <= din1; g2 <= g1; g3 <= g2;
    end
    assign dout0 = mode & ^h3;
    assign dout1 = g3[0];
    assign dout2 = din2[0];
    always @(posedge clk) ncyc <= ncyc + 1;

    function automatic logic [15:0] pat(input logic [15:0] s, input int k);
        logic [15:0] x;
        x = (s == 16'h0) ? 16'hACE1 : s;
        for (int i = 0; i < k; i++) x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
        return x;
    endfunction
    function automatic logic resp(input logic [15:0] s, input int k, input logic m);
        logic [15:0] x;
        x = pat(s, k);
        return m & ^x[6:0];
    endfunction
    function automatic logic [15:0] misr(input logic [15:0] g, input logic b);
        return {g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10]} ^ {15'b0, b};
    endfunction
    function automatic logic [15:0] full_sig(input logic [15:0] s, input logic m);
        logic [15:0] g;
        g = '0;
        for (int k = 0; k < N; k++) g = misr(g, resp(s, k, m));
        return g;
    endfunction

    // model: m_t is the cycle index after the accepted start edge (1 = first DUT_RST cycle)
    logic        m_run, m_done, m_pass, m_ok;
    logic [15:0] m_seed, m_gold, m_sig;
    int          m_t;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_ok <= 1'b1; m_sig <= '0; m_t <= 0;
        end else if (!m_run && start) begin
            m_run <= 1'b1; m_t <= 1; m_done <= 1'b0; m_pass <= 1'b0; m_ok <= 1'b1; m_sig <= '0;
            m_seed <= seed; m_gold <= golden;
        end else if (m_run && abort) begin
            m_run <= 1'b0; m_ok <= 1'b0;
        end else if (m_run) begin
            if (m_t >= 3 + L && m_t <= 2 + N + L) m_sig <= misr(m_sig, resp(m_seed, m_t - 3 - L, mode));
            if (m_t == 3 + N + L) begin
                m_run <= 1'b0; m_done <= 1'b1; m_pass <= (m_sig == m_gold);
            end else
                m_t <= m_t + 1;
        end
    end
    function automatic logic [6:0] exp_din();
        logic [15:0] x;
        if (m_run && m_t > 2) x = pat(m_seed, (m_t - 3 < N) ? m_t - 3 : N - 1);
        else if (m_done) x = pat(m_seed, N - 1);
        else x = '0;
        return x[6:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_ok++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy0, m_run);
            chk("done", done0, m_done);
            chk("pass", pass0, m_pass);
            chk("dut_rst", drst0, rst_n && !(m_run && m_t <= 2));
            chk("dut_in", din0, exp_din());
            if (m_ok) chk("signature", sig0, m_sig);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic go(input logic [15:0] s, input logic [15:0] g, input logic m);
        seed = s; golden = g; mode = m; start = 1'b1;
        cyc();
        start = 1'b0; e0 = ncyc;
    endtask
    task automatic wait_done();
        for (int i = 0; i < 600 && !done0; i++) cyc();
        chk("done_seen", done0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; seed = '0; golden = '0; chk_on = 1'b0;
        cyc(3);
        chk("rst_busy", busy0, 0); chk("rst_done", done0, 0); chk("rst_pass", pass0, 0);
        chk("rst_dut_rst", drst0, 0); chk("rst_dut_in", din0, 0); chk("rst_sig", sig0, 0);
        rst_n = 1'b1; chk_on = 1'b1;
        cyc(2);
        go(16'h0001, 16'h0000, 1'b0);
        chk("t1_dut_rst_a", drst0, 0); cyc();
        chk("t1_dut_rst_b", drst0, 0); cyc();
        chk("t1_dut_rst_hi", drst0, 1);
        for (int k = 0; k < 4; k++) begin chk("t1_pat", din0, 7'(1 << k)); cyc(); end
        wait_done();
        chk("t1_done_edge", ncyc - e0, 262); chk("t1_sig", sig0, 16'h0000); chk("t1_pass", pass0, 1);
        go(16'h0000, 16'h1234, 1'b0);
        cyc(2);
        chk("t2_pat0", din0, 7'h61);
        wait_done();
        chk("t2_pass", pass0, 0); chk("t2_sig", sig0, 16'h0000);
        go(16'h0001, 16'h0008, 1'b1);
        cyc(12);
        chk("t3_lat3_done", done1, 1); chk("t3_lat3_sig", sig1, 16'h0008); chk("t3_lat3_pass", pass1, 1);
        chk("t3_lat0_done", done2, 1); chk("t3_lat0_sig", sig2, 16'h0008); chk("t3_lat0_pass", pass2, 1);
        wait_done();
        chk("t3_u0_sig", sig0, full_sig(16'h0001, 1'b1));
        go(16'hBEEF, 16'h0000, 1'b1);
        cyc(12);
        chk("t4_busy_pre", busy0, 1);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("t4_busy", busy0, 0); chk("t4_done", done0, 0); chk("t4_dut_rst", drst0, 1); chk("t4_dut_in", din0, 0);
        go(16'hBEEF, full_sig(16'hBEEF, 1'b1), 1'b1);
        wait_done();
        chk("t4_edge", ncyc - e0, 262); chk("t4_pass", pass0, 1); chk("t4_sig", sig0, full_sig(16'hBEEF, 1'b1));
        go(16'h0001, 16'h0000, 1'b1);
        cyc(50);
        seed = 16'h0005; start = 1'b1; cyc(); start = 1'b0;
        wait_done();
        chk("t5_edge", ncyc - e0, 262); chk("t5_sig", sig0, full_sig(16'h0001, 1'b1));
        go(16'h0001, 16'h0000, 1'b1);
        cyc(258);
        chk("t6_busy_drain", busy0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy0, 0); chk("t6_done", done0, 0); chk("t6_pass", pass0, 0);
        chk("t6_dut_rst", drst0, 0); chk("t6_dut_in", din0, 0); chk("t6_sig", sig0, 0);
        cyc();
        rst_n = 1'b1;
        cyc(2);
        chk("t6_idle_busy", busy0, 0); chk("t6_idle_dut_rst", drst0, 1);
        go(16'h001D, full_sig(16'h001D, 1'b1), 1'b1);
        wait_done();
        chk("t7_pass_a", pass0, 1);
        start = 1'b1; cyc(); start = 1'b0; e0 = ncyc;
        chk("t7_done_drop", done0, 0); chk("t7_busy", busy0, 1);
        wait_done();
        chk("t7_edge", ncyc - e0, 262); chk("t7_sig", sig0, full_sig(16'h001D, 1'b1)); chk("t7_pass_b", pass0, 1);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_ok, n_tot);
        $finish;
    end
endmodule

// File: doc/bist_seq_ctrl.md
Name: bist_seq_ctrl

Overview:
- Built-in self-test sequencer for one trojan-detection subcircuit under test (DUT): a small netlist of DFFARX1 flops and gates, with a handful of data inputs and one output.
- Resets the DUT, drives it with an LFSR pseudo-random pattern stream, and compacts the delayed DUT response into a MISR signature.
- Compares the signature against a golden value and reports pass/fail.
- Sits between the test harness and each benchmark subcircuit instance.

Parameters:
- N_IN, 7, DUT data input count (1..16); dut_in = lfsr[N_IN-1:0].
- N_PAT, 256, patterns applied per run (1..65535).
- LAT, 3, DUT input-to-output latency in cycles (0..15).
- SEED_DEF, 16'hACE1, LFSR seed substituted when the seed input is zero.

Ports:
- sys_clk, in, 1, single clock; all state on the rising edge.
- sys_rst, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle run request; sampled only in IDLE or DONE.
- abort, in, 1, cancels a run in progress.
- seed, in, 16, LFSR seed, latched when start is accepted.
- golden_sig, in, 16, expected signature, latched when start is accepted.
- dut_in, out, N_IN, pattern bus to the DUT inputs.
- dut_rst, out, 1, active-low reset to the DUT flops.
- dut_out, in, 1, DUT output.
- busy, out, 1, high in DUT_RST, APPLY, DRAIN, CMP.
- done, out, 1, high in DONE.
- pass, out, 1, compare result; meaningful only while done=1.
- signature, out, 16, current MISR value.

Behaviour:
- Reset (sys_rst=0, asynchronous): state=IDLE, dut_in=0, dut_rst=0, busy=0, done=0, pass=0, signature=0, LFSR=0, counters=0, valid pipe cleared. Mid-run reset aborts with no residue.
- Outside reset, dut_rst=1 except in DUT_RST.
- FSM states: IDLE, DUT_RST, APPLY, DRAIN, CMP, DONE.
- IDLE/DONE, start=1:
  - Latch golden_sig.
  - LFSR <= (seed==0 ? SEED_DEF : seed); MISR <= 0; done <= 0; pass <= 0.
  - Go to DUT_RST.
- DUT_RST: dut_rst=0 for exactly 2 cycles, dut_in=0, then APPLY.
- APPLY: N_PAT cycles.
  - Cycle k (0..N_PAT-1) presents pattern k on dut_in.
  - LFSR steps every APPLY cycle: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shift left, feedback into bit0 = b15^b13^b12^b10.
  - Pattern 0 is the seed itself.
  - After the last pattern, go to DRAIN; dut_in holds its last value.
- Valid pipe: a LAT-deep shift of the "pattern applied" flag.
  - dut_out is captured in cycle k+LAT for pattern k.
  - LAT=0 captures in the same cycle as the pattern is applied.
- MISR: on each valid cycle, sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {15'b0, dut_out}. Exactly N_PAT captures per run.
- DRAIN: LAT cycles (skipped when LAT=0), then CMP.
- CMP: one cycle; pass <= (signature == latched golden); go to DONE.
- DONE: done=1 and pass hold until the next accepted start. signature stays stable.
- Timing: with start sampled at edge E0, done rises at E0+2+N_PAT+LAT+1 (262 with defaults). busy is high from E0+1 up to that edge.
- start while busy: ignored, no effect.
- abort while busy:
  - Next edge goes to IDLE with busy=0, done=0, pass=0, dut_in=0, dut_rst=1.
  - signature keeps its partial value.
- abort and start in the same cycle in IDLE/DONE: start wins; abort is a no-op when not busy.
- Counters are sized to hold N_PAT and LAT without wrap. The pattern counter never wraps within a run.

Test Plan:
- Defaults, seed=16'h0001, dut_out tied 0, golden_sig=0 → dut_rst low for 2 cycles; first four dut_in = 7'h01, 02, 04, 08; done rises at E0+262; signature=0; pass=1.
- Seed=0, dut_out tied 0, golden_sig=16'h1234 → pattern 0 = 7'h61 (SEED_DEF[6:0]); done=1; pass=0; signature=0.
- LAT=3, N_PAT=4, dut_out = model echoing dut_in[0] delayed 3 cycles, seed=16'h0001:
  - Responses are 1,0,0,0; MISR steps 0→1→2→4→8.
  - Expect signature=16'h0008 with 4 captures.
  - Same run with LAT=0 and an undelayed echo → identical signature.
- Abort asserted on APPLY cycle 10 → busy=0 at the next edge, done=0, dut_rst=1; a subsequent start completes a full run with the correct signature.
- start pulsed again mid-APPLY → no restart; done timing unchanged. sys_rst=0 mid-DRAIN → all outputs immediately at reset values, including dut_rst=0.
- Back-to-back: start asserted in the first DONE cycle → done drops next edge; the second run reproduces the same signature for the same seed.
